vote_cu_param: RTL and testbench

//  Parametrised voting control unit for the ballot/control-unit pair.

---
 rtl/vote_cu_param.sv | 218 +++++++++++++++++++++
 tb/tb_vote_cu_param.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_cu_param.sv
// Voting control unit: per-candidate tallies with timeout, invalid-code rejection
// and saturation, plus stepped result display and a post-close winner/tie scan.
module vote_cu_param #(
  parameter int N_CAND    = 16,
  parameter int IN_W      = 5,
  parameter int CNT_W     = 12,
  parameter int BALLOT_TO = 255
) (
  input  logic             clk,
  input  logic             Power,
  input  logic             Close,
  input  logic             Clear,
  input  logic             Ballot,
  input  logic             Total,
  input  logic             Result,
  input  logic             Next,
  input  logic [IN_W-1:0]  IN,
  output logic [CNT_W-1:0] out,
  output logic [IN_W-1:0]  cand,
  output logic             armed,
  output logic             vote_ack,
  output logic             vote_rej,
  output logic             sat,
  output logic [IN_W-1:0]  winner,
  output logic             tie,
  output logic             winner_vld
);

  localparam int               TO_W    = $clog2(BALLOT_TO + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BALLOT_TO - 1);
  localparam logic [IN_W-1:0]  N_CODE  = IN_W'(N_CAND);
  localparam logic [IN_W-1:0]  CODE_1  = IN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_TOTAL, S_CLOSED, S_RESULT, S_CLEAR
  } state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [IN_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] tally_q [N_CAND];
  logic [CNT_W-1:0] tally_d [N_CAND];
  logic [CNT_W-1:0] total_q, total_d, out_q, out_d;
  logic             sat_q, sat_d, armed_q, ack_q, rej_q, next_q;
  logic             count_en, rej_d, next_rise, code_ok, code_high;

  logic             scan_act_q, run_tie_q, tie_q, vld_q;
  logic [IN_W-1:0]  scan_idx_q, best_idx_q, winner_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d, scan_cnt;
  logic             take, run_tie_d, scan_start, scan_abort;

  assign code_ok   = (IN != '0) && (IN <= N_CODE);
  assign code_high = (IN > N_CODE);
  assign next_rise = Next && !next_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    timer_d  = '0;
    count_en = 1'b0;
    rej_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if      (Clear)  state_d = S_CLEAR;
        else if (Close)  state_d = S_CLOSED;
        else if (Ballot) state_d = S_ARMED;
        else if (Total)  state_d = S_TOTAL;
      end
      S_ARMED: begin
        timer_d = timer_q + 1'b1;
        // Close and timeout discard the ballot even when a valid code arrives with them.
        if (Close || timer_q == TO_LAST) begin
          state_d = S_IDLE;
        end else if (code_ok) begin
          count_en = 1'b1;
          state_d  = S_IDLE;
        end else if (code_high) begin
          rej_d = 1'b1;
        end
      end
      S_TOTAL:  if (!Total) state_d = S_IDLE;
      S_CLOSED: begin
        if      (Clear)  state_d = S_CLEAR;
        else if (!Close) state_d = S_IDLE;
        else if (Result) begin
          state_d = S_RESULT;
          cand_d  = CODE_1;
        end
      end
      S_RESULT: begin
        if (Clear || !Result) begin
          state_d = Clear ? S_CLEAR : S_CLOSED;
          cand_d  = '0;
        end else if (next_rise) begin
          cand_d = (cand_q == N_CODE) ? CODE_1 : cand_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tally_d = tally_q;
    total_d = total_q;
    sat_d   = sat_q;
    if (state_d == S_CLEAR) begin
      tally_d = '{default: '0};
      total_d = '0;
      sat_d   = 1'b0;
    end else if (count_en) begin
      if (total_q != CNT_MAX) total_d = total_q + 1'b1;
      if (total_d == CNT_MAX) sat_d = 1'b1;
      for (int i = 0; i < N_CAND; i++) begin
        if (IN == IN_W'(i + 1)) begin
          if (tally_q[i] != CNT_MAX) tally_d[i] = tally_q[i] + 1'b1;
          if (tally_d[i] == CNT_MAX) sat_d = 1'b1;
        end
      end
    end
  end

  // Display value follows the state being entered, so out lines up with state.
  always_comb begin
    out_d = '0;
    unique case (state_d)
      S_TOTAL, S_CLOSED: out_d = total_d;
      S_RESULT: begin
        for (int i = 0; i < N_CAND; i++)
          if (cand_d == IN_W'(i + 1)) out_d = tally_d[i];
      end
      default: out_d = '0;
    endcase
  end

  // One candidate per cycle; the first step always seeds the running best.
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_CAND; i++)
      if (scan_idx_q == IN_W'(i + 1)) scan_cnt = tally_q[i];
    take       = (scan_idx_q == CODE_1) || (scan_cnt > best_cnt_q);
    best_idx_d = take ? scan_idx_q : best_idx_q;
    best_cnt_d = take ? scan_cnt : best_cnt_q;
    run_tie_d  = take ? 1'b0 : (run_tie_q || (scan_cnt == best_cnt_q));
  end

  assign scan_start = (state_q == S_IDLE) && (state_d == S_CLOSED);
  assign scan_abort = ((state_q == S_CLOSED) || (state_q == S_RESULT)) &&
                      ((state_d == S_IDLE) || (state_d == S_CLEAR));

  // NOTE: the tally array is a register bank, not a RAM, so it takes the async reset too.
  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cand_q     <= '0;
      tally_q    <= '{default: '0};
      total_q    <= '0;
      out_q      <= '0;
      sat_q      <= 1'b0;
      armed_q    <= 1'b0;
      ack_q      <= 1'b0;
      rej_q      <= 1'b0;
      next_q     <= 1'b0;
      scan_act_q <= 1'b0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      run_tie_q  <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cand_q  <= cand_d;
      tally_q <= tally_d;
      total_q <= total_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      armed_q <= (state_d == S_ARMED);
      ack_q   <= count_en;
      rej_q   <= rej_d;
      next_q  <= Next;
      if (scan_abort) begin
        scan_act_q <= 1'b0;
        vld_q      <= 1'b0;
      end else if (scan_start) begin
        scan_act_q <= 1'b1;
        scan_idx_q <= CODE_1;
      end else if (scan_act_q) begin
        best_idx_q <= best_idx_d;
        best_cnt_q <= best_cnt_d;
        run_tie_q  <= run_tie_d;
        if (scan_idx_q == N_CODE) begin
          scan_act_q <= 1'b0;
          winner_q   <= best_idx_d;
          tie_q      <= run_tie_d;
          vld_q      <= 1'b1;
        end else begin
          scan_idx_q <= scan_idx_q + 1'b1;
        end
      end
    end
  end

  assign out        = out_q;
  assign cand       = cand_q;
  assign armed      = armed_q;
  assign vote_ack   = ack_q;
  assign vote_rej   = rej_q;
  assign sat        = sat_q;
  assign winner     = winner_q;
  assign tie        = tie_q;
  assign winner_vld = vld_q;

endmodule

// File: tb/tb_vote_cu_param.sv
// Self-checking bench for vote_cu_param: directed scenarios plus randomized
// elections compared against an arithmetic tally/winner model.
module tb_vote_cu_param;
  localparam int N    = 16;
  localparam int IW   = 5;
  localparam int CW   = 4;
  localparam int TO   = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, Power, Close, Clear, Ballot, Total, Result, Next;
  logic [IW-1:0] IN;
  logic [CW-1:0] out;
  logic [IW-1:0] cand, winner;
  logic          armed, vote_ack, vote_rej, sat, tie, winner_vld;

  int n_checks = 0;
  int n_errors = 0;

  int m_tally [1:N];
  int m_total;
  bit m_sat;
  int obs_tally [1:N];
  int obs_cand [1:N];
  int obs_wrap;

  vote_cu_param #(.N_CAND(N), .IN_W(IW), .CNT_W(CW), .BALLOT_TO(TO)) dut (
    .clk(clk), .Power(Power), .Close(Close), .Clear(Clear), .Ballot(Ballot),
    .Total(Total), .Result(Result), .Next(Next), .IN(IN), .out(out), .cand(cand),
    .armed(armed), .vote_ack(vote_ack), .vote_rej(vote_rej), .sat(sat),
    .winner(winner), .tie(tie), .winner_vld(winner_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void m_clear();
    for (int c = 1; c <= N; c++) m_tally[c] = 0;
    m_total = 0;
    m_sat   = 1'b0;
  endfunction

  function automatic void m_vote(input int c);
    if (m_tally[c] < CMAX) m_tally[c]++;
    if (m_total < CMAX) m_total++;
    if (m_tally[c] == CMAX || m_total == CMAX) m_sat = 1'b1;
  endfunction

  function automatic void m_winner(output int w, output bit t);
    int best = 1;
    int cnt  = 0;
    for (int c = 1; c <= N; c++) if (m_tally[c] > m_tally[best]) best = c;
    for (int c = 1; c <= N; c++) if (m_tally[c] == m_tally[best]) cnt++;
    w = best;
    t = (cnt > 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Power = 1'b1;
    tick();
    Power = 1'b0;
    tick();
    m_clear();
  endtask

  task automatic cast_vote(input int code, output bit acked);
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    IN = IW'(code);
    tick();
    acked = vote_ack;
    IN = '0;
    tick();
  endtask

  task automatic read_total(output int v);
    Total = 1'b1;
    tick();
    v = int'(out);
    Total = 1'b0;
    tick();
  endtask

  task automatic close_scan(output int cyc);
    Close = 1'b1;
    tick();
    cyc = 0;
    while (winner_vld !== 1'b1 && cyc < N + 10) begin
      tick();
      cyc++;
    end
  endtask

  // Expects the unit in CLOSED; walks every candidate and returns to CLOSED.
  task automatic dump_results();
    Result = 1'b1;
    tick();
    for (int c = 1; c <= N; c++) begin
      obs_tally[c] = int'(out);
      obs_cand[c]  = int'(cand);
      Next = 1'b1;
      tick();
      Next = 1'b0;
      tick();
    end
    obs_wrap = int'(cand);
    Result = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Power = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({out, cand, armed, vote_ack, vote_rej, sat, winner, tie, winner_vld} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got out=%0d cand=%0d armed=%b ack=%b rej=%b sat=%b win=%0d tie=%b vld=%b want all 0",
               out, cand, armed, vote_ack, vote_rej, sat, winner, tie, winner_vld);
    end
    Power = 1'b0;
    tick();
    m_clear();
  endtask

  task automatic test_vote_basic();
    int v;
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    n_checks++;
    if (armed !== 1'b1) begin n_errors++; $display("FAIL t1_armed: got %b want 1", armed); end
    IN = 5'd3;
    tick();
    n_checks++;
    if (vote_ack !== 1'b1 || armed !== 1'b0) begin
      n_errors++; $display("FAIL t1_ack: got ack=%b armed=%b want ack=1 armed=0", vote_ack, armed);
    end
    m_vote(3);
    IN = '0;
    tick();
    n_checks++;
    if (vote_ack !== 1'b0) begin n_errors++; $display("FAIL t1_ack_pulse: got %b want 0", vote_ack); end
    read_total(v);
    n_checks++;
    if (v !== m_total) begin n_errors++; $display("FAIL t1_total: got %0d want %0d", v, m_total); end
  endtask

  task automatic test_reject();
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    IN = IW'(N + 1);
    tick();
    n_checks++;
    if (vote_rej !== 1'b1 || armed !== 1'b1 || vote_ack !== 1'b0) begin
      n_errors++; $display("FAIL t2_rej: got rej=%b armed=%b ack=%b want 1 1 0", vote_rej, armed, vote_ack);
    end
    IN = '0;
    tick();
    n_checks++;
    if (vote_rej !== 1'b0 || armed !== 1'b1) begin
      n_errors++; $display("FAIL t2_wait: got rej=%b armed=%b want 0 1", vote_rej, armed);
    end
    IN = 5'd2;
    tick();
    n_checks++;
    if (vote_ack !== 1'b1) begin n_errors++; $display("FAIL t2_ack: got %b want 1", vote_ack); end
    m_vote(2);
    IN = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n, v, cyc, w;
    bit t, a;
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    n = 0;
    while (armed === 1'b1 && n < 5 * TO) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== TO) begin n_errors++; $display("FAIL t3_timeout_len: got %0d want %0d", n, TO); end
    read_total(v);
    n_checks++;
    if (v !== m_total) begin n_errors++; $display("FAIL t3_total_after_to: got %0d want %0d", v, m_total); end
    // Close together with a valid code discards the ballot.
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    Close = 1'b1;
    IN = 5'd5;
    tick();
    n_checks++;
    if (vote_ack !== 1'b0 || armed !== 1'b0) begin
      n_errors++; $display("FAIL t3_close_discard: got ack=%b armed=%b want 0 0", vote_ack, armed);
    end
    Close = 1'b0;
    IN = '0;
    tick();
    // Clear and a repeated Ballot are both ignored while armed.
    Ballot = 1'b1;
    tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    Ballot = 1'b0;
    n_checks++;
    if (armed !== 1'b1) begin n_errors++; $display("FAIL t3_clear_in_armed: got %b want 1", armed); end
    IN = 5'd6;
    tick();
    a = vote_ack;
    IN = '0;
    tick();
    n_checks++;
    if (a !== 1'b1) begin n_errors++; $display("FAIL t3_ack_after_clear: got %b want 1", a); end
    m_vote(6);
    read_total(v);
    n_checks++;
    if (v !== m_total) begin n_errors++; $display("FAIL t3_total: got %0d want %0d", v, m_total); end
    close_scan(cyc);
    m_winner(w, t);
    n_checks++;
    if (int'(winner) !== w || tie !== t) begin
      n_errors++; $display("FAIL t3_winner: got %0d/%b want %0d/%b", winner, tie, w, t);
    end
    dump_results();
    for (int c = 1; c <= N; c++) begin
      n_checks++;
      if (obs_tally[c] !== m_tally[c]) begin
        n_errors++; $display("FAIL t3_tally%0d: got %0d want %0d", c, obs_tally[c], m_tally[c]);
      end
    end
    Close = 1'b0;
    tick();
  endtask

  task automatic test_winner_result();
    int cyc, acks;
    bit a;
    do_reset();
    acks = 0;
    foreach (m_tally[c]) m_tally[c] = 0;
    for (int k = 0; k < 5; k++) begin
      int code;
      code = (k < 2) ? 3 : (k < 4) ? 7 : 1;
      cast_vote(code, a);
      if (a) acks++;
      m_vote(code);
    end
    n_checks++;
    if (acks !== 5) begin n_errors++; $display("FAIL t4_acks: got %0d want 5", acks); end
    close_scan(cyc);
    n_checks++;
    if (cyc !== N) begin n_errors++; $display("FAIL t4_scan_len: got %0d want %0d", cyc, N); end
    n_checks++;
    if (out !== CW'(5) || winner !== IW'(3) || tie !== 1'b1) begin
      n_errors++; $display("FAIL t4_closed: got out=%0d win=%0d tie=%b want 5 3 1", out, winner, tie);
    end
    Result = 1'b1;
    tick();
    n_checks++;
    if (cand !== IW'(1) || out !== CW'(1)) begin
      n_errors++; $display("FAIL t4_result_entry: got cand=%0d out=%0d want 1 1", cand, out);
    end
    for (int k = 0; k < 3; k++) begin Next = 1'b1; tick(); Next = 1'b0; tick(); end
    n_checks++;
    if (cand !== IW'(4) || out !== CW'(0)) begin
      n_errors++; $display("FAIL t4_step3: got cand=%0d out=%0d want 4 0", cand, out);
    end
    for (int k = 0; k < N - 4; k++) begin Next = 1'b1; tick(); Next = 1'b0; tick(); end
    n_checks++;
    if (cand !== IW'(N)) begin n_errors++; $display("FAIL t4_last: got cand=%0d want %0d", cand, N); end
    Next = 1'b1;
    tick();
    Next = 1'b0;
    tick();
    n_checks++;
    if (cand !== IW'(1) || out !== CW'(1)) begin
      n_errors++; $display("FAIL t4_wrap: got cand=%0d out=%0d want 1 1", cand, out);
    end
    Result = 1'b0;
    tick();
    n_checks++;
    if (cand !== '0 || out !== CW'(5) || winner_vld !== 1'b1) begin
      n_errors++; $display("FAIL t4_back_closed: got cand=%0d out=%0d vld=%b want 0 5 1", cand, out, winner_vld);
    end
    Close = 1'b0;
    tick();
    n_checks++;
    if (winner_vld !== 1'b0 || out !== '0) begin
      n_errors++; $display("FAIL t4_reopen: got vld=%b out=%0d want 0 0", winner_vld, out);
    end
  endtask

  task automatic test_saturation();
    int acks, first_sat, v, cyc;
    bit a;
    do_reset();
    acks = 0;
    first_sat = 0;
    for (int i = 1; i <= 17; i++) begin
      cast_vote(2, a);
      if (a) acks++;
      m_vote(2);
      if (sat === 1'b1 && first_sat == 0) first_sat = i;
    end
    n_checks++;
    if (acks !== 17) begin n_errors++; $display("FAIL t5_acks: got %0d want 17", acks); end
    n_checks++;
    if (first_sat !== CMAX) begin n_errors++; $display("FAIL t5_sat_at: got %0d want %0d", first_sat, CMAX); end
    read_total(v);
    n_checks++;
    if (v !== m_total) begin n_errors++; $display("FAIL t5_total: got %0d want %0d", v, m_total); end
    close_scan(cyc);
    n_checks++;
    if (winner !== IW'(2) || tie !== 1'b0) begin
      n_errors++; $display("FAIL t5_winner: got %0d/%b want 2/0", winner, tie);
    end
    dump_results();
    n_checks++;
    if (obs_tally[2] !== m_tally[2]) begin
      n_errors++; $display("FAIL t5_tally2: got %0d want %0d", obs_tally[2], m_tally[2]);
    end
    Close = 1'b0;
    tick();
    n_checks++;
    if (sat !== 1'b1) begin n_errors++; $display("FAIL t5_sat_sticky: got %b want 1", sat); end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick();
    m_clear();
    read_total(v);
    n_checks++;
    if (sat !== 1'b0 || v !== 0) begin
      n_errors++; $display("FAIL t5_clear: got sat=%b total=%0d want 0 0", sat, v);
    end
  endtask

  task automatic test_power_and_clear();
    int v, cyc, w;
    bit a, t;
    do_reset();
    cast_vote(5, a);
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    IN = 5'd4;
    #2;
    Power = 1'b1;
    #1;
    n_checks++;
    if (armed !== 1'b0 || vote_ack !== 1'b0 || out !== '0) begin
      n_errors++; $display("FAIL t6_async_reset: got armed=%b ack=%b out=%0d want 0 0 0", armed, vote_ack, out);
    end
    tick();
    Power = 1'b0;
    IN = '0;
    tick();
    m_clear();
    read_total(v);
    n_checks++;
    if (v !== 0) begin n_errors++; $display("FAIL t6_total_after_reset: got %0d want 0", v); end
    cast_vote(4, a);
    cast_vote(4, a);
    m_vote(4);
    m_vote(4);
    Close = 1'b1;
    tick();
    Result = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin Next = 1'b1; tick(); Next = 1'b0; tick(); end
    n_checks++;
    if (out !== CW'(m_tally[4])) begin n_errors++; $display("FAIL t6_result4: got %0d want %0d", out, m_tally[4]); end
    Clear = 1'b1;
    tick();
    n_checks++;
    if (out !== '0 || cand !== '0) begin
      n_errors++; $display("FAIL t6_clear_in_result: got out=%0d cand=%0d want 0 0", out, cand);
    end
    Clear = 1'b0;
    Result = 1'b0;
    Close = 1'b0;
    tick();
    m_clear();
    close_scan(cyc);
    m_winner(w, t);
    n_checks++;
    if (winner_vld !== 1'b1 || int'(winner) !== w || tie !== t) begin
      n_errors++; $display("FAIL t6_all_zero_winner: got vld=%b %0d/%b want 1 %0d/%b", winner_vld, winner, tie, w, t);
    end
    dump_results();
    n_checks++;
    if (obs_tally[4] !== 0) begin n_errors++; $display("FAIL t6_tally4_cleared: got %0d want 0", obs_tally[4]); end
    Close = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int v, cyc, w, k;
    bit a, t;
    for (int round = 0; round < 5; round++) begin
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      tick();
      m_clear();
      k = $urandom_range(3, 12);
      for (int j = 0; j < k; j++) begin
        int code;
        code = $urandom_range(1, N);
        Ballot = 1'b1;
        tick();
        Ballot = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          IN = IW'($urandom_range(N + 1, (1 << IW) - 1));
          tick();
          n_checks++;
          if (vote_rej !== 1'b1 || armed !== 1'b1) begin
            n_errors++; $display("FAIL rnd_rej: got rej=%b armed=%b want 1 1", vote_rej, armed);
          end
        end
        IN = IW'(code);
        tick();
        a = vote_ack;
        IN = '0;
        tick();
        n_checks++;
        if (a !== 1'b1) begin n_errors++; $display("FAIL rnd_ack: got %b want 1 (code %0d)", a, code); end
        m_vote(code);
      end
      read_total(v);
      n_checks++;
      if (v !== m_total || sat !== m_sat) begin
        n_errors++; $display("FAIL rnd_total: got %0d sat=%b want %0d sat=%b", v, sat, m_total, m_sat);
      end
      close_scan(cyc);
      m_winner(w, t);
      n_checks++;
      if (cyc !== N || int'(winner) !== w || tie !== t) begin
        n_errors++; $display("FAIL rnd_winner: got cyc=%0d %0d/%b want cyc=%0d %0d/%b", cyc, winner, tie, N, w, t);
      end
      dump_results();
      for (int c = 1; c <= N; c++) begin
        n_checks++;
        if (obs_tally[c] !== m_tally[c] || obs_cand[c] !== c) begin
          n_errors++; $display("FAIL rnd_tally%0d: got %0d@%0d want %0d@%0d", c, obs_tally[c], obs_cand[c], m_tally[c], c);
        end
      end
      n_checks++;
      if (obs_wrap !== 1) begin n_errors++; $display("FAIL rnd_wrap: got %0d want 1", obs_wrap); end
      Close = 1'b0;
      tick();
    end
  endtask

  initial begin
    Power = 1'b1; Close = 1'b0; Clear = 1'b0; Ballot = 1'b0;
    Total = 1'b0; Result = 1'b0; Next = 1'b0; IN = '0;
    test_reset();
    test_vote_basic();
    test_reject();
    test_timeout();
    test_winner_result();
    test_saturation();
    test_power_and_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
